fios_operand_loader: RTL and testbench

Upstream feeder of the FIOS Montgomery multiplier. Accepts operands as a 32-bit AXI-Stream from the processor-side DMA, re-slices each operand into s little-endian 17-bit limbs, and writes them one limb per 32-bit BRAM word into port A of the operand BRAM; the multiplier reads port B. After all operands are written it pulses the multiplier start, waits for its done, then re-arms.

---
 rtl/fios_pkg.sv | 18 +
 rtl/limb_shift_buffer.sv | 62 ++++++
 rtl/fios_operand_loader.sv | 121 ++++++++++++
 tb/tb_fios_operand_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fios_pkg.sv
// Shared limb width, operand sizing helpers and loader FSM state type
// for the FIOS Montgomery operand path.
package fios_pkg;

  localparam int LIMB_W = 17;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} fios_state_e;

  // Number of 17-bit limbs per operand; one spare bit of headroom is required.
  function automatic int s_of(input int width);
    return (width + 1) / LIMB_W + 1;
  endfunction

  function automatic int words_of(input int width);
    return (width + 31) / 32;
  endfunction

endpackage

// File: rtl/limb_shift_buffer.sv
// 48-bit little-endian bit buffer: 32-bit words are appended above the held
// bits, 17-bit limbs are popped from the bottom.
module limb_shift_buffer
  import fios_pkg::*;
#(
  parameter int TAIL_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [31:0]       push_data,
  input  logic              push_tail,
  input  logic              pop,
  input  logic              clear,
  output logic [LIMB_W-1:0] limb,
  output logic [5:0]        count,
  output logic [5:0]        count_next
);

  localparam logic [63:0] ONES_32   = 64'hFFFF_FFFF;
  localparam logic [31:0] TAIL_MASK = 32'(ONES_32 >> (32 - TAIL_BITS));
  localparam logic [5:0]  LIMB_CNT  = 6'(LIMB_W);

  logic [47:0] buffer;
  logic [47:0] buffer_next;
  logic [47:0] popped;
  logic [5:0]  popped_count;
  logic [31:0] word;

  // Bits above count are always zero, so a pop past the fill level yields zero padding.
  always_comb begin
    word         = push_tail ? (push_data & TAIL_MASK) : push_data;
    popped       = pop ? (buffer >> LIMB_W) : buffer;
    popped_count = count;
    if (pop) begin
      popped_count = (count >= LIMB_CNT) ? (count - LIMB_CNT) : 6'd0;
    end
    buffer_next = popped;
    count_next  = popped_count;
    if (push) begin
      buffer_next = popped | ({16'd0, word} << popped_count);
      count_next  = popped_count + 6'd32;
    end
    if (clear) begin
      buffer_next = '0;
      count_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer <= '0;
      count  <= '0;
    end else begin
      buffer <= buffer_next;
      count  <= count_next;
    end
  end

  assign limb = buffer[LIMB_W-1:0];

endmodule

// File: rtl/fios_operand_loader.sv
// Re-slices a 32-bit operand stream into 17-bit limbs written one per BRAM
// word, then starts the FIOS multiplier and waits for it to finish.
module fios_operand_loader
  import fios_pkg::*;
#(
  parameter int          WIDTH        = 256,
  parameter int          S            = s_of(WIDTH),
  parameter int          NUM_OPERANDS = 3,
  parameter logic [31:0] BASE_ADDR    = 32'd0
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [31:0]       s_tdata_i,
  input  logic              s_tvalid_i,
  input  logic              s_tlast_i,
  output logic              s_tready_o,
  output logic [31:0]       BRAM_addr_o,
  output logic [LIMB_W-1:0] BRAM_din_o,
  output logic              BRAM_we_o,
  output logic              BRAM_en_o,
  output logic              start_o,
  input  logic              mult_done_i,
  output logic              busy_o,
  output logic              err_o,
  output fios_state_e       state_o
);

  localparam int W   = words_of(WIDTH);
  localparam int WCW = $clog2(W + 1);
  localparam int LCW = $clog2(S + 1);
  localparam int OPW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam logic [WCW-1:0] W_L     = WCW'(W);
  localparam logic [WCW-1:0] W_LAST  = WCW'(W - 1);
  localparam logic [LCW-1:0] S_L     = LCW'(S);
  localparam logic [LCW-1:0] S_LAST  = LCW'(S - 1);
  localparam logic [OPW-1:0] OP_LAST = OPW'(NUM_OPERANDS - 1);

  fios_state_e       state, state_next;
  logic [WCW-1:0]    word_cnt, word_next;
  logic [LCW-1:0]    limb_cnt, limb_next;
  logic [OPW-1:0]    op_cnt, op_next;
  logic [5:0]        fill, fill_next;
  logic [LIMB_W-1:0] limb;
  logic              accept, emit, last_limb, all_words, tail_word;

  // A word transfers on a rising edge where s_tvalid_i and s_tready_o are both
  // high; s_tready_o is registered and only ever high in LOAD with buffer room.
  always_comb begin
    all_words = (word_cnt == W_L);
    tail_word = (word_cnt == W_LAST);
    accept    = (state == LOAD) && s_tvalid_i && s_tready_o;
    emit      = (state == LOAD) && (limb_cnt < S_L) &&
                ((fill >= 6'(LIMB_W)) || all_words);
    last_limb = emit && (limb_cnt == S_LAST);
    word_next = last_limb ? '0 : word_cnt + WCW'(accept);
    limb_next = last_limb ? '0 : limb_cnt + LCW'(emit);
    op_next   = op_cnt;
    if (last_limb) begin
      op_next = (op_cnt == OP_LAST) ? '0 : op_cnt + 1'b1;
    end
    state_next = state;
    case (state)
      IDLE:    if (s_tvalid_i) state_next = LOAD;
      LOAD:    if (last_limb && (op_cnt == OP_LAST)) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (mult_done_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  limb_shift_buffer #(
    .TAIL_BITS (WIDTH - 32 * (W - 1))
  ) u_buffer (
    .clk        (clock_i),
    .rst_n      (reset_n_i),
    .push       (accept),
    .push_data  (s_tdata_i),
    .push_tail  (tail_word),
    .pop        (emit),
    .clear      (last_limb),
    .limb       (limb),
    .count      (fill),
    .count_next (fill_next)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      word_cnt    <= '0;
      limb_cnt    <= '0;
      op_cnt      <= '0;
      s_tready_o  <= 1'b0;
      BRAM_we_o   <= 1'b0;
      BRAM_en_o   <= 1'b0;
      BRAM_addr_o <= '0;
      BRAM_din_o  <= '0;
      start_o     <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state      <= state_next;
      word_cnt   <= word_next;
      limb_cnt   <= limb_next;
      op_cnt     <= op_next;
      s_tready_o <= (state_next == LOAD) && (fill_next <= 6'd16) && (word_next < W_L);
      BRAM_we_o  <= emit;
      BRAM_en_o  <= emit;
      if (emit) begin
        BRAM_addr_o <= BASE_ADDR + 32'(op_cnt) * 32'(S) + 32'(limb_cnt);
        BRAM_din_o  <= limb;
      end
      start_o <= (state == START);
      busy_o  <= (state_next != IDLE);
      // Framing follows the word counter; tlast is only cross-checked.
      if (accept && (s_tlast_i != tail_word)) err_o <= 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_fios_operand_loader.sv
// Bench for fios_operand_loader: two WIDTH=256 instances (base 0 and 0x100)
// share one stream, a WIDTH=32 instance runs its own jobs.
module tb_fios_operand_loader;
  import fios_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic [31:0] tdata, tdata_c;
  logic        tvalid, tlast, mult_done, tvalid_c, tlast_c, done_c;
  logic        tready_a, we_a, en_a, start_a, busy_a, err_a;
  logic        tready_b, we_b, en_b, start_b, busy_b, err_b;
  logic        tready_c, we_c, en_c, start_c, busy_c, err_c;
  logic [31:0] addr_a, addr_b, addr_c;
  logic [16:0] din_a, din_b, din_c;
  fios_state_e state_a, state_b, state_c;

  fios_operand_loader #(.WIDTH(256), .BASE_ADDR(32'h0)) u_dut_a (
    .clock_i(clk), .reset_n_i(rst_n), .s_tdata_i(tdata), .s_tvalid_i(tvalid),
    .s_tlast_i(tlast), .s_tready_o(tready_a), .BRAM_addr_o(addr_a), .BRAM_din_o(din_a),
    .BRAM_we_o(we_a), .BRAM_en_o(en_a), .start_o(start_a), .mult_done_i(mult_done),
    .busy_o(busy_a), .err_o(err_a), .state_o(state_a));

  fios_operand_loader #(.WIDTH(256), .BASE_ADDR(32'h100)) u_dut_b (
    .clock_i(clk), .reset_n_i(rst_n), .s_tdata_i(tdata), .s_tvalid_i(tvalid),
    .s_tlast_i(tlast), .s_tready_o(tready_b), .BRAM_addr_o(addr_b), .BRAM_din_o(din_b),
    .BRAM_we_o(we_b), .BRAM_en_o(en_b), .start_o(start_b), .mult_done_i(mult_done),
    .busy_o(busy_b), .err_o(err_b), .state_o(state_b));

  fios_operand_loader #(.WIDTH(32), .BASE_ADDR(32'h0)) u_dut_c (
    .clock_i(clk), .reset_n_i(rst_n), .s_tdata_i(tdata_c), .s_tvalid_i(tvalid_c),
    .s_tlast_i(tlast_c), .s_tready_o(tready_c), .BRAM_addr_o(addr_c), .BRAM_din_o(din_c),
    .BRAM_we_o(we_c), .BRAM_en_o(en_c), .start_o(start_c), .mult_done_i(done_c),
    .busy_o(busy_c), .err_o(err_c), .state_o(state_c));

  // ---------------- scoreboard state ----------------
  logic [48:0] exp_a_q[$];
  logic [48:0] exp_b_q[$];
  logic [48:0] exp_c_q[$];
  int errors = 0;
  int checks = 0;
  int start_cnt_a = 0, start_cnt_b = 0, start_cnt_c = 0;
  int wr_cnt_a = 0;
  logic we_prev_a = 1'b0, we_prev_b = 1'b0, we_prev_c = 1'b0;
  logic stuck = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [16:0] model_limb(input logic [255:0] opnd, input int width, input int idx);
    logic [271:0] v;
    v = '0;
    for (int b = 0; b < width; b++) v[b] = opnd[b];
    return v[idx*17 +: 17];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic tready_of(input int sel);
    return (sel == 0) ? tready_a : tready_c;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy_a : busy_c;
  endfunction
  function automatic fios_state_e state_of(input int sel);
    return (sel == 0) ? state_a : state_c;
  endfunction
  function automatic int start_cnt_of(input int sel);
    return (sel == 0) ? start_cnt_a : start_cnt_c;
  endfunction

  // ---------------- output monitors ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (we_a || en_a) check_eq("a_we_en", {62'd0, we_a, en_a}, 64'd3);
      if (we_a) begin
        wr_cnt_a++;
        if (exp_a_q.size() == 0) check_eq("a_unexpected_write", {63'd0, we_a}, 64'd0);
        else check_eq("a_write", {15'd0, addr_a, din_a}, {15'd0, exp_a_q.pop_front()});
      end
      if (start_a) begin
        start_cnt_a++;
        check_eq("a_start_after_last_write", {31'd0, we_prev_a, 32'(exp_a_q.size())},
                 {31'd0, 1'b1, 32'd0});
      end
      if (we_b || en_b) check_eq("b_we_en", {62'd0, we_b, en_b}, 64'd3);
      if (we_b) begin
        if (exp_b_q.size() == 0) check_eq("b_unexpected_write", {63'd0, we_b}, 64'd0);
        else check_eq("b_write", {15'd0, addr_b, din_b}, {15'd0, exp_b_q.pop_front()});
      end
      if (start_b) begin
        start_cnt_b++;
        check_eq("b_start_after_last_write", {31'd0, we_prev_b, 32'(exp_b_q.size())},
                 {31'd0, 1'b1, 32'd0});
      end
      if (we_c || en_c) check_eq("c_we_en", {62'd0, we_c, en_c}, 64'd3);
      if (we_c) begin
        if (exp_c_q.size() == 0) check_eq("c_unexpected_write", {63'd0, we_c}, 64'd0);
        else check_eq("c_write", {15'd0, addr_c, din_c}, {15'd0, exp_c_q.pop_front()});
      end
      if (start_c) begin
        start_cnt_c++;
        check_eq("c_start_after_last_write", {31'd0, we_prev_c, 32'(exp_c_q.size())},
                 {31'd0, 1'b1, 32'd0});
      end
    end
    we_prev_a = we_a;
    we_prev_b = we_b;
    we_prev_c = we_c;
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input int sel, input logic [31:0] data, input logic last, input int gap_max);
    int n;
    int gap;
    if (stuck) return;
    if (sel == 0) begin tdata = data; tlast = last; tvalid = 1'b1; end
    else begin tdata_c = data; tlast_c = last; tvalid_c = 1'b1; end
    n = 0;
    forever begin
      @(negedge clk);
      if (tready_of(sel) === 1'b1) break;
      n++;
      if (n > 200) begin
        check_eq("tready_timeout", {63'd0, tready_of(sel)}, 64'd1);
        stuck = 1'b1;
        return;
      end
    end
    @(posedge clk);
    #1;
    if (gap_max > 0) begin
      gap = $urandom_range(0, gap_max);
      if (gap > 0) begin
        if (sel == 0) tvalid = 1'b0; else tvalid_c = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_job(input int sel, input logic [255:0] x, input logic [255:0] y,
                         input logic [255:0] m, input int gap_max, input int bad_op,
                         input int bad_word, input int abort_after);
    logic [255:0] opv [3];
    int words, s, width, wr_base;
    logic last;
    opv[0] = x; opv[1] = y; opv[2] = m;
    words = (sel == 0) ? 8 : 1;
    s     = (sel == 0) ? 16 : 2;
    width = (sel == 0) ? 256 : 32;
    wr_base = wr_cnt_a;
    for (int o = 0; o < 3; o++) begin
      for (int l = 0; l < s; l++) begin
        if (sel == 0) begin
          exp_a_q.push_back({32'(o * s + l), model_limb(opv[o], width, l)});
          exp_b_q.push_back({32'(32'h100 + o * s + l), model_limb(opv[o], width, l)});
        end else begin
          exp_c_q.push_back({32'(o * s + l), model_limb(opv[o], width, l)});
        end
      end
    end
    for (int o = 0; o < 3; o++) begin
      for (int w = 0; w < words; w++) begin
        if (abort_after > 0 && (wr_cnt_a - wr_base) >= abort_after) return;
        last = (w == words - 1) || (o == bad_op && w == bad_word);
        if (o == bad_op && w == bad_word) check_eq("err_before_bad_tlast", {63'd0, err_a}, 64'd0);
        send_word(sel, opv[o][w*32 +: 32], last, gap_max);
        if (o == bad_op && w == bad_word) begin
          @(negedge clk);
          check_eq("err_after_bad_tlast", {63'd0, err_a}, 64'd1);
        end
      end
    end
    if (sel == 0) tvalid = 1'b0; else tvalid_c = 1'b0;
  endtask

  task automatic finish_job(input int sel, input int target, input int delay);
    int n, bad_ready, bad_busy;
    n = 0;
    while (start_cnt_of(sel) < target && n < 800) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_pulse_count", 64'(start_cnt_of(sel)), 64'(target));
    if (sel == 0) check_eq("b_start_pulse_count", 64'(start_cnt_b), 64'(target));
    bad_ready = 0;
    bad_busy  = 0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (tready_of(sel) !== 1'b0) bad_ready++;
      if (busy_of(sel) !== 1'b1) bad_busy++;
    end
    check_eq("wait_tready_low_cycles_bad", 64'(bad_ready), 64'd0);
    check_eq("wait_busy_high_cycles_bad", 64'(bad_busy), 64'd0);
    if (sel == 0) mult_done = 1'b1; else done_c = 1'b1;
    @(posedge clk);
    #1;
    if (sel == 0) mult_done = 1'b0; else done_c = 1'b0;
    @(negedge clk);
    check_eq("busy_after_done", {63'd0, busy_of(sel)}, 64'd0);
    check_eq("state_after_done", 64'(state_of(sel)), 64'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  localparam logic [255:0] ALL_ONES = '1;
  localparam logic [255:0] M_EDGE   = (256'd1 << 255) | 256'd1;

  initial begin
    int jobs_ab;
    logic [255:0] nx;
    rst_n = 1'b0;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0; mult_done = 1'b0;
    tdata_c = '0; tvalid_c = 1'b0; tlast_c = 1'b0; done_c = 1'b0;
    jobs_ab = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs_a", {tready_a, we_a, en_a, start_a, busy_a, err_a, addr_a, din_a}, 64'd0);
    check_eq("reset_outputs_c", {tready_c, we_c, en_c, start_c, busy_c, err_c, addr_c, din_c}, 64'd0);
    check_eq("reset_state_a", 64'(state_a), 64'(IDLE));
    rst_n = 1'b1;

    // done pulse outside WAIT must be ignored
    @(posedge clk); #1 mult_done = 1'b1;
    @(posedge clk); #1 mult_done = 1'b0;
    @(negedge clk);
    check_eq("done_in_idle_ignored", {62'd0, busy_a, state_a != IDLE}, 64'd0);

    // job 1: directed operands, continuous valid
    run_job(0, ALL_ONES, 256'd1, M_EDGE, 0, -1, -1, 0);
    jobs_ab++;
    finish_job(0, jobs_ab, 5);

    // job 2: random operands with random valid gaps
    run_job(0, rand256(), rand256(), rand256(), 3, -1, -1, 0);
    jobs_ab++;
    finish_job(0, jobs_ab, 3);

    // job 3: early tlast on word 6 of operand 1
    run_job(0, rand256(), rand256(), rand256(), 0, 1, 6, 0);
    jobs_ab++;
    finish_job(0, jobs_ab, 3);
    check_eq("err_sticky", {62'd0, err_a, err_b}, 64'd3);

    // job 4: aborted by reset after about 20 writes
    run_job(0, rand256(), rand256(), rand256(), 0, -1, -1, 20);
    rst_n = 1'b0;
    #1;
    check_eq("reset_mid_load_outputs", {tready_a, we_a, en_a, start_a, busy_a, err_a, addr_a, din_a}, 64'd0);
    check_eq("reset_mid_load_state", 64'(state_a), 64'(IDLE));
    tvalid = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // job 5: full job after reset; next job's first word held valid through WAIT
    run_job(0, ALL_ONES, 256'd1, M_EDGE, 0, -1, -1, 0);
    jobs_ab++;
    nx = rand256();
    tdata = nx[31:0]; tlast = 1'b0; tvalid = 1'b1;
    finish_job(0, jobs_ab, 50);

    // job 6: follows the held word
    run_job(0, nx, rand256(), rand256(), 2, -1, -1, 0);
    jobs_ab++;
    finish_job(0, jobs_ab, 2);

    // narrow instance: WIDTH=32, two limbs per operand
    run_job(1, 256'hFFFF_FFFF, 256'(32'h1357_9BDF), 256'(32'h0001_8000), 0, -1, -1, 0);
    finish_job(1, 1, 2);
    run_job(1, 256'($urandom), 256'($urandom), 256'($urandom), 2, -1, -1, 0);
    finish_job(1, 2, 2);

    repeat (5) @(negedge clk);
    check_eq("a_queue_drained", 64'(exp_a_q.size()), 64'd0);
    check_eq("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
    check_eq("c_queue_drained", 64'(exp_c_q.size()), 64'd0);
    check_eq("a_total_starts", 64'(start_cnt_a), 64'(jobs_ab));
    check_eq("c_total_starts", 64'(start_cnt_c), 64'd2);
    check_eq("c_err_clear", {63'd0, err_c}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
